// File: rtl/chess_layout_streamer.sv
// rtl/chess_layout_streamer.sv - renders a captured 8x8 chess layout as a 32x32 RGB565 pixel stream
// Each square is 4x4 pixels; highlight rings take the outer pixels, the piece takes the 2x2 interior.
module chess_layout_streamer #(
   parameter int CHESS_SQUARES = 64,
   parameter int SQUARE_WIDTH  = 8,
   parameter int MATRIX_WIDTH  = CHESS_SQUARES*SQUARE_WIDTH
) (
   input  logic                    OutClock,
   input  logic                    resetApp,
   input  logic [MATRIX_WIDTH-1:0] Layout,
   input  logic                    FrameStart,
   input  logic                    PixelReady,
   output logic [15:0]             PixelData,
   output logic                    PixelValid,
   output logic [4:0]              PixelX,
   output logic [4:0]              PixelY,
   output logic                    Busy,
   output logic                    FrameDone
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   logic [1:0]              r_state;
   logic [MATRIX_WIDTH-1:0] r_snap;
   logic [9:0]              r_cnt;
   logic [15:0]             r_pix;

   logic [MATRIX_WIDTH-1:0] w_src;
   logic [9:0]              w_cnt;
   logic [5:0]              w_idx;
   logic [6:0]              w_rec;
   logic [1:0]              w_sx;
   logic [1:0]              w_sy;
   logic                    w_border;
   logic                    w_last;
   logic [15:0]             w_color;

   // Pixel 0 is coloured straight from Layout because the snapshot loads on the same edge.
   assign w_src    = (r_state == ST_IDLE) ? Layout : r_snap;
   assign w_cnt    = (r_state == ST_IDLE) ? 10'd0 : r_cnt + 10'd1;
   assign w_idx    = {w_cnt[9:7], w_cnt[4:2]};
   assign w_rec    = w_src[int'(w_idx)*SQUARE_WIDTH +: 7];
   assign w_sx     = w_cnt[1:0];
   assign w_sy     = w_cnt[6:5];
   assign w_border = (w_sx == 2'd0) || (w_sx == 2'd3) || (w_sy == 2'd0) || (w_sy == 2'd3);
   assign w_last   = (r_cnt == 10'd1023);

   always_comb begin
      w_color = 16'h0000;
      if (w_border && w_rec[6])
         w_color = 16'hF800;
      else if (w_border && w_rec[4])
         w_color = 16'hFFE0;
      else if (w_border && w_rec[5])
         w_color = 16'h07E0;
      else if (!w_border && (w_rec[2:0] != 3'd0))
         w_color = w_rec[3] ? 16'hFFFF : 16'h0000;
      else
         w_color = (w_cnt[2] ^ w_cnt[7]) ? 16'h8410 : 16'hC618;
   end

   always_ff @(posedge OutClock or posedge resetApp) begin
      if (resetApp) begin
         r_state <= ST_IDLE;
         r_snap  <= '0;
         r_cnt   <= 10'd0;
         r_pix   <= 16'h0000;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (FrameStart) begin
                  r_snap  <= Layout;
                  r_cnt   <= 10'd0;
                  r_pix   <= w_color;
                  r_state <= ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (PixelReady) begin
                  if (w_last) begin
                     r_cnt   <= 10'd0;
                     r_pix   <= 16'h0000;
                     r_state <= ST_DONE;
                  end else begin
                     r_cnt <= w_cnt;
                     r_pix <= w_color;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // The counter is zero whenever no frame streams, so coordinates read 0 outside STREAM.
   assign PixelData  = r_pix;
   assign PixelX     = r_cnt[4:0];
   assign PixelY     = r_cnt[9:5];
   assign PixelValid = (r_state == ST_STREAM);
   assign Busy       = (r_state != ST_IDLE);
   assign FrameDone  = (r_state == ST_DONE);

endmodule
